// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with req/ready handshake and fixed latency.
// Define MEM_ALIGN_CHECK_EN to flag misaligned/reserved accesses on err instead of forcing alignment.
module data_mem_ctrl #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              ack,
    output logic [31:0]       rdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] op_addr, a0, a1, a2, a3;
    logic              op_we, op_uns, op_mis;
    logic [1:0]        op_size;
    logic [31:0]       op_wdata;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       ld_val;
    logic              commit;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        ack       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_nxt = (LATENCY == 1) ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign op_addr  = (state == IDLE) ? addr        : addr_q;
    assign op_we    = (state == IDLE) ? we          : we_q;
    assign op_size  = (state == IDLE) ? size        : size_q;
    assign op_uns   = (state == IDLE) ? unsigned_ld : uns_q;
    assign op_wdata = (state == IDLE) ? wdata       : wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign op_mis = (op_size == 2'b11) ||
                    (op_size == 2'b01 && op_addr[0]) ||
                    (op_size == 2'b10 && op_addr[1:0] != 2'b00);
`else
    assign op_mis = 1'b0;
`endif

    always_comb begin
        a0 = op_addr;
        unique case (op_size)
            2'b00:   a0 = op_addr;
            2'b01:   a0[0] = 1'b0;
            default: a0[1:0] = 2'b00;
        endcase
    end

    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        ld_val = 32'h0;
        unique case (op_size)
            2'b00:   ld_val = {{24{~op_uns & b0[7]}}, b0};
            2'b01:   ld_val = {{16{~op_uns & b0[7]}}, b0, b1};
            default: ld_val = {b0, b1, b2, b3};
        endcase
    end

    assign commit = (state_nxt == DONE) && !rst && !op_mis;

    always @(posedge clk) begin
        if (commit && op_we) begin
            unique case (op_size)
                2'b00: mem[a0] <= op_wdata[7:0];
                2'b01: begin
                    mem[a0] <= op_wdata[15:8];
                    mem[a1] <= op_wdata[7:0];
                end
                default: begin
                    mem[a0] <= op_wdata[31:24];
                    mem[a1] <= op_wdata[23:16];
                    mem[a2] <= op_wdata[15:8];
                    mem[a3] <= op_wdata[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            rdata   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                we_q    <= we;
                size_q  <= size;
                uns_q   <= unsigned_ld;
                wdata_q <= wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !op_we) rdata <= ld_val;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req) begin
            err_q <= op_mis;
        end
    end

    assign err = ack & err_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl: LATENCY=1 and LATENCY=4 instances.
// Honours MEM_ALIGN_CHECK_EN for the misaligned-store case.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst1, rst4, req1, req4, we, uns;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        ready1, ack1, ready4, ack4;
    logic [31:0] rdata1, rdata4;
`ifdef MEM_ALIGN_CHECK_EN
    logic        err1, err4;
`endif
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst1), .req(req1), .we(we), .size(size),
        .unsigned_ld(uns), .addr(addr), .wdata(wdata),
        .ready(ready1), .ack(ack1), .rdata(rdata1)
`ifdef MEM_ALIGN_CHECK_EN
        , .err(err1)
`endif
    );

    data_mem_ctrl #(.DEPTH(1024), .ADDR_W(10), .LATENCY(4)) u4 (
        .clk(clk), .rst(rst4), .req(req4), .we(we), .size(size),
        .unsigned_ld(uns), .addr(addr), .wdata(wdata),
        .ready(ready4), .ack(ack4), .rdata(rdata4)
`ifdef MEM_ALIGN_CHECK_EN
        , .err(err4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic acc1(input logic w, input logic [1:0] sz, input logic u,
                        input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = d; req1 = 1'b1;
        chk("rdy1", {31'b0, ready1}, 32'd1);
        @(negedge clk);
        req1 = 1'b0;
        chk("ack1", {31'b0, ack1}, 32'd1);
        @(negedge clk);
        chk("ack1_drop", {31'b0, ack1}, 32'd0);
    endtask

    task automatic acc4(input logic w, input logic [1:0] sz,
                        input logic [9:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        we = w; size = sz; uns = 1'b0; addr = a; wdata = d; req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        n = 1;
        while (!ack4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat4", n, 32'd4);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] exp_rdy;
        logic [9:0] exp_ack;
        rst1 = 1'b1; rst4 = 1'b1; req1 = 1'b0; req4 = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready1", {31'b0, ready1}, 32'd1);
        chk("rst_ack1", {31'b0, ack1}, 32'd0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_ready4", {31'b0, ready4}, 32'd1);
        rst1 = 1'b0; rst4 = 1'b0;

        acc1(1'b1, 2'b10, 1'b0, 10'd8, 32'h12345678);
        acc1(1'b0, 2'b10, 1'b0, 10'd8, 32'h0);
        chk("ld_word8", rdata1, 32'h12345678);
        acc1(1'b0, 2'b00, 1'b0, 10'd8, 32'h0);
        chk("ld_byte8", rdata1, 32'h00000012);
        acc1(1'b0, 2'b00, 1'b0, 10'd11, 32'h0);
        chk("ld_byte11", rdata1, 32'h00000078);

        acc1(1'b1, 2'b10, 1'b0, 10'd20, 32'h11223344);
        chk("st_keeps_rdata", rdata1, 32'h00000078);
        acc1(1'b1, 2'b00, 1'b0, 10'd20, 32'h00000080);
        acc1(1'b0, 2'b00, 1'b0, 10'd20, 32'h0);
        chk("ld_byte_s", rdata1, 32'hFFFFFF80);
        acc1(1'b0, 2'b00, 1'b1, 10'd20, 32'h0);
        chk("ld_byte_u", rdata1, 32'h00000080);
        acc1(1'b0, 2'b10, 1'b0, 10'd20, 32'h0);
        chk("byte_only", rdata1, 32'h80223344);

        acc1(1'b1, 2'b10, 1'b0, 10'd32, 32'h0);
        acc1(1'b1, 2'b01, 1'b0, 10'd34, 32'h0000BEEF);
        acc1(1'b0, 2'b10, 1'b0, 10'd32, 32'h0);
        chk("ld_word32", rdata1, 32'h0000BEEF);
        acc1(1'b0, 2'b01, 1'b0, 10'd34, 32'h0);
        chk("ld_half_s", rdata1, 32'hFFFFBEEF);
        acc1(1'b0, 2'b01, 1'b1, 10'd34, 32'h0);
        chk("ld_half_u", rdata1, 32'h0000BEEF);

        acc1(1'b1, 2'b10, 1'b0, 10'd4, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 10'd6;
        wdata = 32'hCAFEF00D; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        chk("mis_ack", {31'b0, ack1}, 32'd1);
        chk("mis_err", {31'b0, err1}, 32'd1);
        @(negedge clk);
        chk("mis_err_drop", {31'b0, err1}, 32'd0);
        acc1(1'b0, 2'b10, 1'b0, 10'd4, 32'h0);
        chk("mis_nowrite", rdata1, 32'h0);
`else
        acc1(1'b1, 2'b10, 1'b0, 10'd6, 32'hCAFEF00D);
        acc1(1'b0, 2'b10, 1'b0, 10'd4, 32'h0);
        chk("align_word", rdata1, 32'hCAFEF00D);
        acc1(1'b0, 2'b01, 1'b1, 10'd35, 32'h0);
        chk("align_half", rdata1, 32'h0000BEEF);
`endif

        acc4(1'b1, 2'b10, 10'd0, 32'h55667788);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 10'd0; wdata = 32'hAAAAAAAA; req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("rstw_ready", {31'b0, ready4}, 32'd1);
        chk("rstw_ack", {31'b0, ack4}, 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        acc4(1'b0, 2'b10, 10'd0, 32'h0);
        chk("rstw_nowrite", rdata4, 32'h55667788);

        exp_rdy = 10'b1000010000;
        exp_ack = 10'b0100001000;
        @(negedge clk);
        we = 1'b0; size = 2'b00; uns = 1'b1; addr = 10'd1; req4 = 1'b1;
        chk("tp_ready0", {31'b0, ready4}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("tp_ready%0d", i + 1), {31'b0, ready4}, {31'b0, exp_rdy[i]});
            chk($sformatf("tp_ack%0d", i + 1), {31'b0, ack4}, {31'b0, exp_ack[i]});
            if (exp_ack[i]) chk("tp_rdata", rdata4, 32'h00000066);
        end
        req4 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
